// File: rtl/cmat2x2_seq_ctrl_pkg.sv
// Shared constants, FSM state type and 2x2 element-index helpers for the
// cmat2x2_seq_ctrl complex matrix-product sequencer.
package cmat2x2_seq_ctrl_pkg;

  localparam int DATA_W  = 8;
  localparam int PROD_W  = 16;
  localparam int ACC_W   = PROD_W + 1;
  localparam int N_STEPS = 8;
  localparam int STEP_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic elem_row(input logic [1:0] e);
    return e[1];
  endfunction

  function automatic logic elem_col(input logic [1:0] e);
    return e[0];
  endfunction

  function automatic logic [1:0] elem_idx(input logic row, input logic col);
    return {row, col};
  endfunction

endpackage

// File: rtl/cmat2x2_acc_bank.sv
// Four complex accumulators (C elements) with clear, load and add controls,
// addressed by element index e = 2*row+col.
module cmat2x2_acc_bank
  import cmat2x2_seq_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 add,
  input  logic [1:0]           idx,
  input  logic [PROD_W-1:0]    res_real,
  input  logic [PROD_W-1:0]    res_imag,
  output logic [8*ACC_W-1:0]   c_mat
);

  logic [ACC_W-1:0] re_q [4];
  logic [ACC_W-1:0] im_q [4];
  logic [ACC_W-1:0] re_ext_s;
  logic [ACC_W-1:0] im_ext_s;

  assign re_ext_s = {{(ACC_W-PROD_W){res_real[PROD_W-1]}}, res_real};
  assign im_ext_s = {{(ACC_W-PROD_W){res_imag[PROD_W-1]}}, res_imag};

  // Accumulator update: first product of a pair loads, second adds.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int e = 0; e < 4; e++) begin
        re_q[e] <= '0;
        im_q[e] <= '0;
      end
    end else if (en) begin
      if (add) begin
        re_q[idx] <= re_q[idx] + re_ext_s;
        im_q[idx] <= im_q[idx] + im_ext_s;
      end else begin
        re_q[idx] <= re_ext_s;
        im_q[idx] <= im_ext_s;
      end
    end
  end

  // Pack the accumulators onto the C output bus, real in the low half.
  always_comb begin
    c_mat = '0;
    for (int e = 0; e < 4; e++) begin
      c_mat[e*2*ACC_W +: ACC_W]         = re_q[e];
      c_mat[e*2*ACC_W + ACC_W +: ACC_W] = im_q[e];
    end
  end

endmodule

// File: rtl/cmat2x2_seq_ctrl.sv
// 2x2 complex matrix product sequencer driving one external complex multiplier.
// Optional MUL_PIPE_EN registers the multiplier result before accumulation.
module cmat2x2_seq_ctrl
  import cmat2x2_seq_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [8*DATA_W-1:0]  a_mat,
  input  logic [8*DATA_W-1:0]  b_mat,
  output logic                 busy,
  output logic                 done,
  output logic [8*ACC_W-1:0]   c_mat,
  output logic [DATA_W-1:0]    mul_a_real,
  output logic [DATA_W-1:0]    mul_a_imag,
  output logic [DATA_W-1:0]    mul_b_real,
  output logic [DATA_W-1:0]    mul_b_imag,
  input  logic [PROD_W-1:0]    mul_res_real,
  input  logic [PROD_W-1:0]    mul_res_imag
);

`ifdef MUL_PIPE_EN
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N_STEPS);
`else
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N_STEPS - 1);
`endif

  state_t              state_q;
  logic [STEP_W-1:0]   step_q;
  logic [8*DATA_W-1:0] a_q;
  logic [8*DATA_W-1:0] b_q;
  logic                busy_q;
  logic                done_q;

  logic                start_ok_s;
  logic [1:0]          op_e_s;
  logic                op_t_s;
  logic [2*DATA_W-1:0] op_a_s;
  logic [2*DATA_W-1:0] op_b_s;
  logic                acc_en_s;
  logic [2:0]          acc_k_s;
  logic [PROD_W-1:0]   acc_re_s;
  logic [PROD_W-1:0]   acc_im_s;

  assign start_ok_s = (state_q == ST_IDLE) && start;

  // Control FSM with registered busy/done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a_mat;
            b_q     <= b_mat;
            step_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_MUL;
          end
        end
        ST_MUL: begin
          if (step_q == LAST_STEP) begin
            step_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            step_q <= step_q + 4'd1;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Step k issues A[i][t] x B[t][j] with e=k>>1, i=e>>1, j=e&1, t=k&1; zero when idle.
  always_comb begin
    op_e_s = step_q[2:1];
    op_t_s = step_q[0];
    if ((state_q == ST_MUL) && (step_q < STEP_W'(N_STEPS))) begin
      op_a_s = a_q[int'(elem_idx(elem_row(op_e_s), op_t_s))*2*DATA_W +: 2*DATA_W];
      op_b_s = b_q[int'(elem_idx(op_t_s, elem_col(op_e_s)))*2*DATA_W +: 2*DATA_W];
    end else begin
      op_a_s = '0;
      op_b_s = '0;
    end
  end

  assign mul_a_real = op_a_s[DATA_W-1:0];
  assign mul_a_imag = op_a_s[2*DATA_W-1:DATA_W];
  assign mul_b_real = op_b_s[DATA_W-1:0];
  assign mul_b_imag = op_b_s[2*DATA_W-1:DATA_W];

`ifdef MUL_PIPE_EN
  logic [PROD_W-1:0] res_re_q;
  logic [PROD_W-1:0] res_im_q;

  // Product register; step k's result is accumulated one MUL cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_re_q <= '0;
      res_im_q <= '0;
    end else begin
      res_re_q <= mul_res_real;
      res_im_q <= mul_res_imag;
    end
  end

  // Accumulate the step issued in the previous cycle.
  always_comb begin
    acc_en_s = (state_q == ST_MUL) && (step_q != 4'd0);
    acc_k_s  = step_q[2:0] - 3'd1;
    acc_re_s = res_re_q;
    acc_im_s = res_im_q;
  end
`else
  // Accumulate the step being issued this cycle.
  always_comb begin
    acc_en_s = (state_q == ST_MUL);
    acc_k_s  = step_q[2:0];
    acc_re_s = mul_res_real;
    acc_im_s = mul_res_imag;
  end
`endif

  cmat2x2_acc_bank u_acc_bank (
    .clk      (clk),
    .rst      (rst),
    .clr      (start_ok_s),
    .en       (acc_en_s),
    .add      (acc_k_s[0]),
    .idx      (acc_k_s[2:1]),
    .res_real (acc_re_s),
    .res_imag (acc_im_s),
    .c_mat    (c_mat)
  );

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_cmat2x2_seq_ctrl.sv
// Self-checking bench for cmat2x2_seq_ctrl: behavioural multiplier, matrix
// product reference model and per-cycle timing/operand checks.
module tb_cmat2x2_seq_ctrl;
  import cmat2x2_seq_ctrl_pkg::*;

`ifdef MUL_PIPE_EN
  localparam int N_MUL = 9;
`else
  localparam int N_MUL = 8;
`endif
  localparam int LAT = N_MUL + 1;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [8*DATA_W-1:0] a_mat;
  logic [8*DATA_W-1:0] b_mat;
  logic                busy;
  logic                done;
  logic [8*ACC_W-1:0]  c_mat;
  logic [DATA_W-1:0]   mul_a_real, mul_a_imag, mul_b_real, mul_b_imag;
  logic [PROD_W-1:0]   mul_res_real, mul_res_imag;

  int n_checks = 0;
  int n_fail   = 0;
  int ar[4], ai[4], br[4], bi[4];
  int m_pr, m_pi;

  always #5 clk = ~clk;

  cmat2x2_seq_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .a_mat        (a_mat),
    .b_mat        (b_mat),
    .busy         (busy),
    .done         (done),
    .c_mat        (c_mat),
    .mul_a_real   (mul_a_real),
    .mul_a_imag   (mul_a_imag),
    .mul_b_real   (mul_b_real),
    .mul_b_imag   (mul_b_imag),
    .mul_res_real (mul_res_real),
    .mul_res_imag (mul_res_imag)
  );

  // External complex multiplier
  always_comb begin
    m_pr = int'($signed(mul_a_real)) * int'($signed(mul_b_real))
         - int'($signed(mul_a_imag)) * int'($signed(mul_b_imag));
    m_pi = int'($signed(mul_a_real)) * int'($signed(mul_b_imag))
         + int'($signed(mul_a_imag)) * int'($signed(mul_b_real));
  end
  assign mul_res_real = m_pr[15:0];
  assign mul_res_imag = m_pi[15:0];

  task automatic check_val(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack_in(input int re[4], input int im[4]);
    logic [63:0] v;
    v = '0;
    for (int e = 0; e < 4; e++) begin
      v[e*16 +: 8]     = 8'(re[e]);
      v[e*16 + 8 +: 8] = 8'(im[e]);
    end
    return v;
  endfunction

  function automatic logic [135:0] model_c();
    logic [135:0] v;
    v = '0;
    for (int e = 0; e < 4; e++) begin
      int cr, ci, ea, eb;
      cr = 0;
      ci = 0;
      for (int t = 0; t < 2; t++) begin
        ea = 2 * (e / 2) + t;
        eb = 2 * t + (e % 2);
        cr += ar[ea] * br[eb] - ai[ea] * bi[eb];
        ci += ar[ea] * bi[eb] + ai[ea] * br[eb];
      end
      v[e*34 +: 17]      = 17'(cr);
      v[e*34 + 17 +: 17] = 17'(ci);
    end
    return v;
  endfunction

  function automatic logic [31:0] exp_op(input int k);
    int e, ea, eb, t;
    e  = k / 2;
    t  = k % 2;
    ea = 2 * (e / 2) + t;
    eb = 2 * t + (e % 2);
    return {8'(bi[eb]), 8'(br[eb]), 8'(ai[ea]), 8'(ar[ea])};
  endfunction

  task automatic rand_mats();
    for (int e = 0; e < 4; e++) begin
      ar[e] = int'($urandom_range(255)) - 128;
      ai[e] = int'($urandom_range(255)) - 128;
      br[e] = int'($urandom_range(255)) - 128;
      bi[e] = int'($urandom_range(255)) - 128;
      if (ar[e] == -128 && ai[e] == -128) ai[e] = -127;
    end
  endtask

  task automatic run_op(input string tag, input bit extra_start, input bit do_rst);
    logic [135:0] c_exp;
    logic [31:0]  op_exp;
    c_exp = model_c();
    a_mat = pack_in(ar, ai);
    b_mat = pack_in(br, bi);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a_mat = {$urandom, $urandom};
    b_mat = {$urandom, $urandom};
    for (int i = 1; i <= LAT; i++) begin
      if (do_rst && i == 5) begin
        rst = 1'b0;
        check_val({tag, "_rst_busy"}, busy, 1'b0);
        check_val({tag, "_rst_done"}, done, 1'b0);
        check_val({tag, "_rst_c"}, c_mat, '0);
        check_val({tag, "_rst_ops"}, {mul_b_imag, mul_b_real, mul_a_imag, mul_a_real}, '0);
        for (int w = 0; w < LAT + 2; w++) begin
          @(negedge clk);
          check_val({tag, "_rst_nodone"}, done, 1'b0);
          check_val({tag, "_rst_idle"}, busy, 1'b0);
        end
        return;
      end
      check_val({tag, "_busy"}, busy, (i <= N_MUL));
      check_val({tag, "_done"}, done, (i == LAT));
      op_exp = (i <= N_STEPS) ? exp_op(i - 1) : 32'd0;
      check_val({tag, "_ops"}, {mul_b_imag, mul_b_real, mul_a_imag, mul_a_real}, op_exp);
      if (i == LAT) check_val({tag, "_c"}, c_mat, c_exp);
      start = extra_start && (i == 3 || i == LAT);
      rst   = do_rst && (i == 4);
      @(negedge clk);
    end
    start = 1'b0;
    check_val({tag, "_post_busy"}, busy, 1'b0);
    check_val({tag, "_post_done"}, done, 1'b0);
    check_val({tag, "_c_hold"}, c_mat, c_exp);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a_mat = '0;
    b_mat = '0;
    repeat (3) @(negedge clk);
    check_val("reset_busy", busy, 1'b0);
    check_val("reset_done", done, 1'b0);
    check_val("reset_c", c_mat, '0);
    check_val("reset_ops", {mul_b_imag, mul_b_real, mul_a_imag, mul_a_real}, '0);
    rst = 1'b0;
    @(negedge clk);

    for (int e = 0; e < 4; e++) begin
      ar[e] = 2; ai[e] = 3; br[e] = 4; bi[e] = 5;
    end
    run_op("uniform", 1'b0, 1'b0);
    check_val("uniform_c00", c_mat[33:0], {17'(44), 17'(-14)});

    ar = '{1, 0, 0, 1};
    ai = '{0, 0, 0, 0};
    br = '{1, 3, -5, 7};
    bi = '{2, -4, 6, 8};
    run_op("ident", 1'b0, 1'b0);

    for (int e = 0; e < 4; e++) begin
      ar[e] = -128; ai[e] = 0; br[e] = -128; bi[e] = 0;
    end
    run_op("width", 1'b0, 1'b0);

    rand_mats();
    run_op("ignore", 1'b1, 1'b0);

    rand_mats();
    run_op("abort", 1'b0, 1'b1);

    for (int n = 0; n < 6; n++) begin
      rand_mats();
      run_op("b2b", 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
